// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and memory-wait holds.
// Control outputs are combinational (same cycle); MEM_BUSY freezes the whole pipe and parks the stall/flush sequence.
module hazard_ctrl_unit #(
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned BRANCH_FLUSHES  = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead_EX,
  input  logic [4:0]       RD_EX,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USE_RS1_ID,
  input  logic             USE_RS2_ID,
  input  logic             BRANCH_TAKEN,
  input  logic             MEM_BUSY,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, BR_FLUSH, MEM_WAIT} state_e;

  localparam logic [3:0]       LU_RELOAD = 4'(LOAD_USE_STALLS - 1);
  localparam logic [3:0]       BR_RELOAD = 4'(BRANCH_FLUSHES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;
  state_e           eff_state;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             pc_w, ifid_w, ifid_f, idex_w, idex_f;

  assign lu = MemRead_EX && (RD_EX != 5'd0) &&
              ((USE_RS1_ID && (RD_EX == RS1_ID)) || (USE_RS2_ID && (RD_EX == RS2_ID)));

  // Leaving MEM_WAIT resumes the parked state in the same cycle, so no slot is lost.
  assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

  always_comb begin
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_w  = 1'b1;
    idex_f  = 1'b0;
    state_d = RUN;
    saved_d = saved_q;
    cnt_d   = cnt_q;

    if (MEM_BUSY) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) saved_d = state_q;
    end else if (BRANCH_TAKEN) begin
      ifid_f = 1'b1;
      idex_f = 1'b1;
      if (BRANCH_FLUSHES > 1) begin
        state_d = BR_FLUSH;
        cnt_d   = BR_RELOAD;
      end else begin
        cnt_d   = 4'd0;
      end
    end else if (lu) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_f = 1'b1;
      if (LOAD_USE_STALLS > 1) begin
        state_d = LOAD_STALL;
        cnt_d   = LU_RELOAD;
      end else begin
        cnt_d   = 4'd0;
      end
    end else begin
      case (eff_state)
        LOAD_STALL: begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_f  = 1'b1;
          cnt_d   = (cnt_q > 4'd1) ? cnt_q - 4'd1 : 4'd0;
          state_d = (cnt_q > 4'd1) ? LOAD_STALL : RUN;
        end
        BR_FLUSH: begin
          ifid_f  = 1'b1;
          idex_f  = 1'b1;
          cnt_d   = (cnt_q > 4'd1) ? cnt_q - 4'd1 : 4'd0;
          state_d = (cnt_q > 4'd1) ? BR_FLUSH : RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_w && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (ifid_f && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      saved_q     <= RUN;
      cnt_q       <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset forces a free-running pipe regardless of hazard inputs.
  assign PC_write    = reset ? 1'b1 : pc_w;
  assign IF_ID_write = reset ? 1'b1 : ifid_w;
  assign IF_ID_flush = reset ? 1'b0 : ifid_f;
  assign ID_EX_write = reset ? 1'b1 : idex_w;
  assign ID_EX_flush = reset ? 1'b0 : idex_f;
  assign STALL_CNT   = stall_cnt_q;
  assign FLUSH_CNT   = flush_cnt_q;

endmodule
